// File: rtl/mdu_writeback.sv
// Iterative RV32M multiply/divide unit: bit-serial shift-add multiply and restoring
// divide, with a one-cycle registered write into the register file on completion.
module mdu_writeback #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic            RegWrite,
   output logic [4:0]      Write_Register,
   output logic [XLEN-1:0] Write_Data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_REM    = 3'd6;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic             neg_q, neg_d;
   // opa: multiplicand / divisor; lo: multiplier then product low half / dividend then quotient;
   // acc: product high half / partial remainder (one extra bit for the restoring compare).
   logic [XLEN-1:0]  opa_q, opa_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN:0]    acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             regwrite_q, regwrite_d;
   logic [4:0]       wreg_q, wreg_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;

   // ---------------- operand decode at issue ----------------
   logic            sgn_a, sgn_b;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            neg_in;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;

   always_comb begin
      sgn_a = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
              (funct3 == F_DIV)  || (funct3 == F_REM);
      sgn_b = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
      a_neg = sgn_a & rs1_data[XLEN-1];
      b_neg = sgn_b & rs2_data[XLEN-1];
      mag_a = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      mag_b = b_neg ? (~rs2_data + 1'b1) : rs2_data;

      // Remainder follows the dividend; quotient and high product follow the XOR.
      case (funct3)
         F_MULH:   neg_in = a_neg ^ b_neg;
         F_MULHSU: neg_in = a_neg;
         F_DIV:    neg_in = a_neg ^ b_neg;
         F_REM:    neg_in = a_neg;
         default:  neg_in = 1'b0;
      endcase

      div_zero = funct3[2] && (rs2_data == '0);
      div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
      special  = div_zero || div_ovf;

      if (div_zero)
         special_res = funct3[1] ? rs1_data : ALL_ONES;
      else
         special_res = funct3[1] ? '0 : INT_MIN;
   end

   // ---------------- one iteration of the datapath ----------------
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   div_diff;
   logic [XLEN:0]     acc_nx;
   logic [XLEN-1:0]   lo_nx;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   div_raw;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opa_q} : '0);
      rem_sh   = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
      div_diff = {1'b0, rem_sh} - {2'b00, opa_q};

      if (!op_q[2]) begin
         acc_nx = {1'b0, mul_sum[XLEN:1]};
         lo_nx  = {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN+1]) begin
         acc_nx = div_diff[XLEN:0];
         lo_nx  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         acc_nx = rem_sh;
         lo_nx  = {lo_q[XLEN-2:0], 1'b0};
      end

      prod    = {acc_nx[XLEN-1:0], lo_nx};
      prod_s  = neg_q ? (~prod + 1'b1) : prod;
      div_raw = op_q[1] ? acc_nx[XLEN-1:0] : lo_nx;

      if (!op_q[2])
         final_res = (op_q == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      else
         final_res = neg_q ? (~div_raw + 1'b1) : div_raw;
   end

   // ---------------- next-state / output logic ----------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      rd_d       = rd_q;
      neg_d      = neg_q;
      opa_d      = opa_q;
      lo_d       = lo_q;
      acc_d      = acc_q;
      done_d     = 1'b0;
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = funct3;
               rd_d  = rd;
               cnt_d = '0;
               neg_d = neg_in;
               opa_d = funct3[2] ? mag_b : mag_a;
               lo_d  = funct3[2] ? mag_a : mag_b;
               acc_d = '0;
               if (special) begin
                  state_d    = S_DONE;
                  done_d     = 1'b1;
                  regwrite_d = (rd != 5'd0);
                  wreg_d     = rd;
                  wdata_d    = special_res;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = acc_nx;
            lo_d  = lo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               regwrite_d = (rd_q != 5'd0);
               wreg_d     = rd_q;
               wdata_d    = final_res;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         neg_q      <= 1'b0;
         opa_q      <= '0;
         lo_q       <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         neg_q      <= neg_d;
         opa_q      <= opa_d;
         lo_q       <= lo_d;
         acc_q      <= acc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign RegWrite       = regwrite_q;
   assign Write_Register = wreg_q;
   assign Write_Data     = wdata_q;

endmodule

// File: tb/tb_mdu_writeback.sv
// Self-checking bench for mdu_writeback: directed RV32M vectors, special cases, held start,
// mid-operation reset and randomized ops against an arithmetic reference model.
module tb_mdu_writeback;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd;
   logic        busy, done, RegWrite;
   logic [4:0]  Write_Register;
   logic [31:0] Write_Data;

   int checks = 0;
   int errors = 0;

   mdu_writeback #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
      .busy(busy), .done(done), .RegWrite(RegWrite),
      .Write_Register(Write_Register), .Write_Data(Write_Data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics computed with 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, sp, q;
      logic [63:0]        up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      case (f3)
         3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * ub; return sp[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return ALL_ONES;
            if (a == INT_MIN && b == ALL_ONES) return INT_MIN;
            q = sa / sb; return q[31:0];
         end
         3'd5: return (b == 0) ? ALL_ONES : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == INT_MIN && b == ALL_ONES) return 32'd0;
            q = sa % sb; return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == INT_MIN && b == ALL_ONES));
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return INT_MIN;
         2:       return ALL_ONES;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // One full op: issue at E0, then follow it through completion and the cycle after.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdi, input string tag);
      logic [31:0] exp;
      int          lat, exp_lat;
      exp     = ref_model(f3, a, b);
      exp_lat = is_special(f3, a, b) ? 0 : 32;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd = rdi;
      @(posedge clk); #1;
      start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd = 5'($urandom);
      check({tag, ".busy_e0"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".regwrite"}, 32'(RegWrite), 32'(rdi != 5'd0));
      check({tag, ".wreg"}, 32'(Write_Register), 32'(rdi));
      check({tag, ".wdata"}, Write_Data, exp);
      @(posedge clk); #1;
      check({tag, ".done_drop"}, 32'(done), 32'd0);
      check({tag, ".rw_drop"}, 32'(RegWrite), 32'd0);
      check({tag, ".busy_drop"}, 32'(busy), 32'd0);
      check({tag, ".wdata_hold"}, Write_Data, exp);
      $display("op %-10s f3=%0d a=%h b=%h rd=%0d -> %h (latency %0d)", tag, f3, a, b, rdi, Write_Data, lat);
   endtask

   initial begin
      int          rw_seen, pulses, last_c;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;

      rst = 1'b0; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.regwrite", 32'(RegWrite), 32'd0);
      check("reset.wreg", 32'(Write_Register), 32'd0);
      check("reset.wdata", Write_Data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(3'd0, 32'd7, 32'd6, 5'd5, "mul");
      run_op(3'd1, ALL_ONES, ALL_ONES, 5'd6, "mulh");
      run_op(3'd3, ALL_ONES, ALL_ONES, 5'd7, "mulhu");
      run_op(3'd2, ALL_ONES, 32'd2, 5'd8, "mulhsu");
      run_op(3'd4, -32'sd7, 32'd2, 5'd9, "div");
      run_op(3'd6, -32'sd7, 32'd2, 5'd10, "rem");
      run_op(3'd5, 32'd100, 32'd7, 5'd11, "divu");
      run_op(3'd7, 32'd100, 32'd7, 5'd12, "remu");
      run_op(3'd5, 32'd5, 32'd0, 5'd13, "divu0");
      run_op(3'd6, INT_MIN, ALL_ONES, 5'd14, "rem_ovf");
      run_op(3'd4, INT_MIN, ALL_ONES, 5'd15, "div_ovf");
      run_op(3'd6, 32'd9, 32'd0, 5'd16, "rem0");
      run_op(3'd0, 32'd3, 32'd3, 5'd0, "mul_rd0");

      // start held high: each op starts the cycle after DONE, so pulses are XLEN+2 apart.
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1234; rs2_data = 32'd5678; rd = 5'd20;
      pulses = 0; last_c = -1;
      for (int c = 1; c <= 102; c++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            check("held.spacing", 32'(c - last_c), (pulses == 1) ? 32'd34 : 32'd34);
            check("held.wdata", Write_Data, 32'd7006652);
            last_c = c;
         end
         if (c == 102) start = 1'b0;
      end
      check("held.pulses", 32'(pulses), 32'd3);
      $display("op held_start pulses=%0d", pulses);
      repeat (2) @(posedge clk);

      // Reset asserted at E0+10 of a DIV aborts it with no write.
      @(negedge clk);
      start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7; rd = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.regwrite", 32'(RegWrite), 32'd0);
      check("abort.wdata", Write_Data, 32'd0);
      check("abort.wreg", 32'(Write_Register), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rw_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (RegWrite || done) rw_seen++;
      end
      check("abort.no_write", 32'(rw_seen), 32'd0);
      $display("op reset_abort writes_after=%0d", rw_seen);
      run_op(3'd0, 32'd2, 32'd3, 5'd4, "mul_post");

      for (int i = 0; i < 40; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op(rf3, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
